// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO with one cycle of read latency into a
// valid/ready stream through a two-entry skid buffer, plus beat counter and error flag.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  infl_q, infl_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;
  logic                  proto_err_q, proto_err_d;

  logic       pop;
  logic       cap;
  logic [1:0] occ;
  logic [2:0] level;

  assign occ        = state_q;
  assign m_valid    = (state_q != S_EMPTY);
  assign m_data     = head_q;
  assign beat_count = beat_count_q;
  assign proto_err  = proto_err_q;
  assign pop        = m_valid && m_ready;
  assign cap        = infl_q;

  // Occupancy after this edge including the word in flight; a read is only
  // issued when that leaves room, so occ + infl_q never exceeds two.
  assign level      = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
  assign fifo_rd_en = rst_n && !fifo_empty && (level < 3'd2);

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    infl_d       = fifo_rd_en;
    beat_count_d = pop ? beat_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : beat_count_q;
    proto_err_d  = proto_err_q | (fifo_underflow && infl_q);

    unique case (state_q)
      S_EMPTY: begin
        if (cap) begin
          state_d = S_ONE;
          head_d  = fifo_data_out;
        end
      end
      S_ONE: begin
        if (cap && !pop) begin
          state_d = S_TWO;
          tail_d  = fifo_data_out;
        end else if (cap && pop) begin
          head_d = fifo_data_out;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (cap) begin
            tail_d = fifo_data_out;
          end else begin
            state_d = S_ONE;
          end
        end else if (cap) begin
          // A capture with a full buffer means the read gating was violated; drop it.
          proto_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      infl_q       <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      beat_count_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      infl_q       <= infl_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      beat_count_q <= beat_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
